// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register indices, CTRL fields,
// pattern modes, bounce direction and FSM state encoding.
package led_seq_pkg;

  localparam logic [1:0] REG_SEED   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_RUN_BIT  = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_DUTY_LSB = 8;
  localparam int unsigned CTRL_DUTY_MSB = 15;

  typedef enum logic [1:0] {
    ModeStatic = 2'b00,
    ModeBlink  = 2'b01,
    ModeRotate = 2'b10,
    ModeBounce = 2'b11
  } mode_e;

  typedef enum logic {
    DirLeft  = 1'b0,
    DirRight = 1'b1
  } dir_e;

  // Encoding is visible to software through STATUS[17:16].
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } state_e;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Slave-register access bus between the AXI-Lite decode and the LED pattern sequencer.
interface led_pattern_sequencer_if #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
  logic                          slv_reg_wren;
  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_awaddr;
  logic [31:0]                   S_AXI_WDATA;
  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_araddr;
  logic [31:0]                   rd_data;

  modport master (
    output slv_reg_wren,
    output axi_awaddr,
    output S_AXI_WDATA,
    output axi_araddr,
    input  rd_data
  );

  modport slave (
    input  slv_reg_wren,
    input  axi_awaddr,
    input  S_AXI_WDATA,
    input  axi_araddr,
    output rd_data
  );
endinterface

// File: rtl/led_step_unit.sv
// Combinational next-pattern generator: one step of the selected LED pattern mode,
// plus the bounce direction update.
module led_step_unit
  import led_seq_pkg::*;
(
  input  logic [7:0] pattern,
  input  mode_e      mode,
  input  dir_e       dir,
  input  logic [7:0] seed,
  output logic [7:0] next_pattern,
  output dir_e       next_dir
);

  always_comb begin
    next_pattern = pattern;
    next_dir     = dir;
    unique case (mode)
      ModeStatic: next_pattern = pattern;
      ModeBlink:  next_pattern = (pattern == seed) ? 8'h00 : seed;
      ModeRotate: next_pattern = {pattern[6:0], pattern[7]};
      ModeBounce: begin
        // Direction flips on the step that lands on an edge bit.
        if (dir == DirLeft) begin
          next_pattern = {pattern[6:0], 1'b0};
          if (next_pattern[7]) next_dir = DirRight;
        end else begin
          next_pattern = {1'b0, pattern[7:1]};
          if (next_pattern[0]) next_dir = DirLeft;
        end
      end
    endcase
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Register-programmed LED pattern sequencer (static, blink, rotate, bounce).
// Optional PWM dimming of the LED bank is enabled with `define LED_SEQ_PWM_EN.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_PERIOD_WIDTH     = 24
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  led_pattern_sequencer_if.slave bus,
  output logic                   step_tick,
  output logic [7:0]             LED
);

  localparam logic [C_PERIOD_WIDTH-1:0] PeriodOne = {{(C_PERIOD_WIDTH-1){1'b0}}, 1'b1};

  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr, raddr;
  logic [31:0]                   wdata;
  logic [1:0]                    wr_idx, rd_idx;
  logic                          seed_wr, ctrl_wr, period_wr;

  assign waddr  = bus.axi_awaddr;
  assign raddr  = bus.axi_araddr;
  assign wdata  = bus.S_AXI_WDATA;
  assign wr_idx = waddr[3:2];
  assign rd_idx = raddr[3:2];

  assign seed_wr   = bus.slv_reg_wren && (wr_idx == REG_SEED);
  assign ctrl_wr   = bus.slv_reg_wren && (wr_idx == REG_CTRL);
  assign period_wr = bus.slv_reg_wren && (wr_idx == REG_PERIOD);

  logic [7:0]                seed_q, seed_d, load_seed_q, load_seed_d;
  logic                      run_q, run_d;
  mode_e                     mode_q, mode_d;
  logic [C_PERIOD_WIDTH-1:0] period_q, period_d, presc_q, presc_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [7:0]                pattern_q, pattern_d, step_pattern, base_d, led_d;
  dir_e                      dir_q, dir_d, step_dir;
  state_e                    state_q, state_d;
  logic                      step_d, terminal;
  logic                      pwm_gate;
  logic [7:0]                duty_rd;

  assign seed_d   = seed_wr ? wdata[7:0] : seed_q;
  assign run_d    = ctrl_wr ? wdata[CTRL_RUN_BIT] : run_q;
  assign mode_d   = ctrl_wr ? mode_e'(wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]) : mode_q;
  assign period_d = period_wr ? wdata[C_PERIOD_WIDTH-1:0] : period_q;

  // PERIOD of 0 behaves as 1: every RUN cycle is a terminal cycle.
  assign terminal = (period_q == '0) || (presc_q == (period_q - PeriodOne));

  led_step_unit u_step (
    .pattern      (pattern_q),
    .mode         (mode_q),
    .dir          (dir_q),
    .seed         (load_seed_q),
    .next_pattern (step_pattern),
    .next_dir     (step_dir)
  );

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    dir_d       = dir_q;
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    load_seed_d = load_seed_q;
    step_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_d) state_d = StLoad;
      end
      StLoad: begin
        pattern_d   = seed_q;
        load_seed_d = seed_q;
        presc_d     = '0;
        dir_d       = DirLeft;
        cnt_d       = 16'd0;
        if (ctrl_wr && run_d) state_d = StLoad;
        else if (run_d)       state_d = StRun;
        else                  state_d = StIdle;
      end
      StRun: begin
        // A CTRL write always beats a coincident step.
        if (ctrl_wr) begin
          state_d = run_d ? StLoad : StIdle;
        end else if (!run_q) begin
          state_d = StIdle;
        end else if (terminal) begin
          presc_d   = '0;
          pattern_d = step_pattern;
          dir_d     = step_dir;
          cnt_d     = cnt_q + 16'd1;
          step_d    = 1'b1;
        end else begin
          presc_d = presc_q + PeriodOne;
        end
      end
      default: state_d = StIdle;
    endcase
    if (period_wr) presc_d = '0;
  end

  // LED is registered from next-state values so it tracks state/pattern on the same edge.
  assign base_d = (state_d == StRun) ? pattern_d : seed_d;
  assign led_d  = base_d & {8{pwm_gate}};

`ifdef LED_SEQ_PWM_EN
  logic [7:0] duty_q, duty_d, pwm_cnt_q, pwm_cnt_d;

  assign duty_d    = ctrl_wr ? wdata[CTRL_DUTY_MSB:CTRL_DUTY_LSB] : duty_q;
  assign pwm_cnt_d = pwm_cnt_q + 8'd1;
  assign pwm_gate  = (duty_d == 8'hFF) || (pwm_cnt_d < duty_d);
  assign duty_rd   = duty_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN) begin
      duty_q    <= 8'hFF;
      pwm_cnt_q <= 8'h00;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  assign pwm_gate = 1'b1;
  assign duty_rd  = 8'h00;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN) begin
      seed_q      <= 8'h00;
      run_q       <= 1'b0;
      mode_q      <= ModeStatic;
      period_q    <= '0;
      presc_q     <= '0;
      cnt_q       <= 16'd0;
      pattern_q   <= 8'h00;
      load_seed_q <= 8'h00;
      dir_q       <= DirLeft;
      state_q     <= StIdle;
      step_tick   <= 1'b0;
      LED         <= 8'h00;
    end else begin
      seed_q      <= seed_d;
      run_q       <= run_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      pattern_q   <= pattern_d;
      load_seed_q <= load_seed_d;
      dir_q       <= dir_d;
      state_q     <= state_d;
      step_tick   <= step_d;
      LED         <= led_d;
    end
  end

  logic [31:0] rd_word;

  always_comb begin
    rd_word = 32'h0;
    unique case (rd_idx)
      REG_SEED:   rd_word = {24'h0, seed_q};
      REG_CTRL:   rd_word = {16'h0, duty_rd, 5'h0, mode_q, run_q};
      REG_PERIOD: rd_word = 32'(period_q);
      REG_STATUS: rd_word = {14'h0, state_q, cnt_q};
      default:    rd_word = 32'h0;
    endcase
  end

  assign bus.rd_data = rd_word;

  // Address byte-lane bits and upper write-data bits carry no register state.
  logic unused_bits;
  assign unused_bits = ^{waddr, raddr, wdata};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed, table-driven bench for led_pattern_sequencer (default and LED_SEQ_PWM_EN builds).
module tb_led_pattern_sequencer;

`ifdef LED_SEQ_PWM_EN
  localparam logic [31:0] CR = 32'h0000_FF00;
`else
  localparam logic [31:0] CR = 32'h0000_0000;
`endif
  // Full duty is always written so the pattern checks hold in both builds.
  localparam logic [31:0] DF = 32'h0000_FF00;

  logic S_AXI_ACLK = 1'b0;
  logic S_AXI_ARESETN;
  logic step_tick;
  logic [7:0] LED;

  led_pattern_sequencer_if #(.C_S_AXI_ADDR_WIDTH(4)) bus ();

  led_pattern_sequencer #(
    .C_S_AXI_ADDR_WIDTH (4),
    .C_PERIOD_WIDTH     (24)
  ) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .bus           (bus),
    .step_tick     (step_tick),
    .LED           (LED)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  typedef struct {
    logic        wren;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [7:0]  led;
    logic        tick;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[19];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] ra);
    bus.slv_reg_wren = w;
    bus.axi_awaddr   = a;
    bus.S_AXI_WDATA  = d;
    bus.axi_araddr   = ra;
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic cyc(input string name, input logic w, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] ra, input logic [7:0] led,
                     input logic tick, input logic [31:0] rd);
    drive(w, a, d, ra);
    chk({name, "_led"}, {24'h0, LED}, {24'h0, led});
    chk({name, "_tick"}, {31'h0, step_tick}, {31'h0, tick});
    chk({name, "_rd"}, bus.rd_data, rd);
  endtask

  logic [7:0] bexp[16];
  int         on_cnt, off_cnt;

  initial begin
    // Static at PERIOD=0, then stop, then rotate at PERIOD=4.
    vecs[0]  = '{1'b1, 4'h0, 32'hA5,       4'h0, 8'hA5, 1'b0, 32'hA5};
    vecs[1]  = '{1'b1, 4'h4, DF | 32'h1,   4'h4, 8'hA5, 1'b0, CR | 32'h1};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,        4'hC, 8'hA5, 1'b0, 32'h2_0000};
    vecs[3]  = '{1'b0, 4'h0, 32'h0,        4'hC, 8'hA5, 1'b1, 32'h2_0001};
    vecs[4]  = '{1'b0, 4'h0, 32'h0,        4'hC, 8'hA5, 1'b1, 32'h2_0002};
    vecs[5]  = '{1'b0, 4'h0, 32'h0,        4'hC, 8'hA5, 1'b1, 32'h2_0003};
    vecs[6]  = '{1'b1, 4'h4, DF,           4'hC, 8'hA5, 1'b0, 32'h0_0003};
    vecs[7]  = '{1'b1, 4'h0, 32'h81,       4'h0, 8'h81, 1'b0, 32'h81};
    vecs[8]  = '{1'b1, 4'h8, 32'h4,        4'h8, 8'h81, 1'b0, 32'h4};
    vecs[9]  = '{1'b1, 4'h4, DF | 32'h5,   4'h4, 8'h81, 1'b0, CR | 32'h5};
    vecs[10] = '{1'b0, 4'h0, 32'h0,        4'hC, 8'h81, 1'b0, 32'h2_0000};
    vecs[11] = '{1'b0, 4'h0, 32'h0,        4'hC, 8'h81, 1'b0, 32'h2_0000};
    vecs[12] = '{1'b0, 4'h0, 32'h0,        4'hC, 8'h81, 1'b0, 32'h2_0000};
    vecs[13] = '{1'b0, 4'h0, 32'h0,        4'hC, 8'h81, 1'b0, 32'h2_0000};
    vecs[14] = '{1'b0, 4'h0, 32'h0,        4'hC, 8'h03, 1'b1, 32'h2_0001};
    vecs[15] = '{1'b0, 4'h0, 32'h0,        4'hC, 8'h03, 1'b0, 32'h2_0001};
    vecs[16] = '{1'b0, 4'h0, 32'h0,        4'hC, 8'h03, 1'b0, 32'h2_0001};
    vecs[17] = '{1'b0, 4'h0, 32'h0,        4'hC, 8'h03, 1'b0, 32'h2_0001};
    vecs[18] = '{1'b0, 4'h0, 32'h0,        4'hC, 8'h06, 1'b1, 32'h2_0002};
    bexp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

    // Reset held 3 cycles; a concurrent SEED write must be ignored.
    S_AXI_ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h0, 32'hFF, 4'h0);
      chk($sformatf("rst%0d_led", i), {24'h0, LED}, 32'h0);
      chk($sformatf("rst%0d_tick", i), {31'h0, step_tick}, 32'h0);
    end
    bus.slv_reg_wren = 1'b0;
    S_AXI_ARESETN    = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus.axi_araddr = 4'(r * 4);
      #1;
      chk($sformatf("rst_reg%0d", r), bus.rd_data, (r == 1) ? CR : 32'h0);
    end

    for (int i = 0; i < 19; i++)
      cyc($sformatf("vec%0d", i), vecs[i].wren, vecs[i].addr, vecs[i].wdata, vecs[i].raddr,
          vecs[i].led, vecs[i].tick, vecs[i].rd);

    // SEED write while running is deferred; CTRL write on a terminal cycle wins.
    cyc("seed_defer", 1'b1, 4'h0, 32'h01, 4'h0, 8'h06, 1'b0, 32'h01);
    cyc("period1",    1'b1, 4'h8, 32'h1,  4'h8, 8'h06, 1'b0, 32'h1);
    cyc("bnc_load",   1'b1, 4'h4, DF | 32'h7, 4'hC, 8'h01, 1'b0, 32'h1_0002);
    cyc("bnc_entry",  1'b0, 4'h0, 32'h0, 4'hC, 8'h01, 1'b0, 32'h2_0000);
    for (int i = 0; i < 16; i++)
      cyc($sformatf("bnc%0d", i), 1'b0, 4'h0, 32'h0, 4'hC, bexp[i], 1'b1, 32'h2_0000 + i + 1);

    // Stop, blink, mid-period restart, restart on terminal cycle, stop.
    cyc("bnc_stop",  1'b1, 4'h4, DF, 4'hC, 8'h01, 1'b0, 32'h0_0010);
    cyc("blk_seed",  1'b1, 4'h0, 32'h3C, 4'h0, 8'h3C, 1'b0, 32'h3C);
    cyc("blk_per",   1'b1, 4'h8, 32'h4,  4'h8, 8'h3C, 1'b0, 32'h4);
    cyc("blk_load",  1'b1, 4'h4, DF | 32'h3, 4'h4, 8'h3C, 1'b0, CR | 32'h3);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("blk_a%0d", i), 1'b0, 4'h0, 32'h0, 4'hC, 8'h3C, 1'b0, 32'h2_0000);
    cyc("blk_off",   1'b0, 4'h0, 32'h0, 4'hC, 8'h00, 1'b1, 32'h2_0001);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("blk_b%0d", i), 1'b0, 4'h0, 32'h0, 4'hC, 8'h00, 1'b0, 32'h2_0001);
    cyc("blk_on",    1'b0, 4'h0, 32'h0, 4'hC, 8'h3C, 1'b1, 32'h2_0002);
    cyc("blk_mid",   1'b0, 4'h0, 32'h0, 4'hC, 8'h3C, 1'b0, 32'h2_0002);
    cyc("rst_mid",   1'b1, 4'h4, DF | 32'h5, 4'hC, 8'h3C, 1'b0, 32'h1_0002);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("rot_a%0d", i), 1'b0, 4'h0, 32'h0, 4'hC, 8'h3C, 1'b0, 32'h2_0000);
    cyc("rst_term",  1'b1, 4'h4, DF | 32'h5, 4'hC, 8'h3C, 1'b0, 32'h1_0000);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("rot_b%0d", i), 1'b0, 4'h0, 32'h0, 4'hC, 8'h3C, 1'b0, 32'h2_0000);
    cyc("rot_step",  1'b0, 4'h0, 32'h0, 4'hC, 8'h78, 1'b1, 32'h2_0001);
    cyc("rot_stop",  1'b1, 4'h4, DF, 4'hC, 8'h3C, 1'b0, 32'h0_0001);

    // PWM duty 0x40 (or ignored DUTY in the default build).
    cyc("pwm_seed",  1'b1, 4'h0, 32'hFF, 4'h0, 8'hFF, 1'b0, 32'hFF);
    drive(1'b1, 4'h4, 32'h4001, 4'h4);
`ifdef LED_SEQ_PWM_EN
    chk("pwm_ctrl_rd", bus.rd_data, 32'h4001);
`else
    chk("pwm_ctrl_rd", bus.rd_data, 32'h0001);
`endif
    on_cnt  = 0;
    off_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 4'h0, 32'h0, 4'hC);
      if (LED == 8'hFF) on_cnt++;
      else if (LED == 8'h00) off_cnt++;
    end
`ifdef LED_SEQ_PWM_EN
    chk("pwm_on_cycles", on_cnt, 64);
    chk("pwm_off_cycles", off_cnt, 192);
`else
    chk("pwm_on_cycles", on_cnt, 256);
`endif

    // Reset while running.
    S_AXI_ARESETN = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 4'hC);
    chk("rrun_led", {24'h0, LED}, 32'h0);
    chk("rrun_tick", {31'h0, step_tick}, 32'h0);
    chk("rrun_status", bus.rd_data, 32'h0);
    S_AXI_ARESETN = 1'b0;
    for (int i = 0; i < 2; i++)
      cyc($sformatf("rrun_idle%0d", i), 1'b0, 4'h0, 32'h0, 4'h4, 8'h00, 1'b0, CR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
AXI-Lite-attached controller that sequences the 8-bit LED bank instead of driving it with a raw written value. Software programs seed, mode and step period through slave-register writes. The block then steps LED patterns (static, blink, rotate, bounce) autonomously. It sits behind the AXI-Lite slave register decode in the custom LED IP and owns the LED output pins.

Parameters:
- C_S_AXI_ADDR_WIDTH, 4, width of AXI byte address; register index = axi_awaddr[3:2] / axi_araddr[3:2]
- C_PERIOD_WIDTH, 24, width of PERIOD register and prescale counter

Ports:
- S_AXI_ACLK  in  1  sole clock, all logic rising-edge
- S_AXI_ARESETN  in  1  synchronous reset, active-high (reset asserted when 1), sampled on S_AXI_ACLK
- slv_reg_wren  in  1  write strobe from AXI slave, one cycle per write
- axi_awaddr  in  C_S_AXI_ADDR_WIDTH  latched write address
- S_AXI_WDATA  in  32  write data
- axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
- rd_data  out  32  combinational readback of register at axi_araddr
- step_tick  out  1  one-cycle pulse on every pattern step
- LED  out  8  LED drive, registered

Behaviour:
- Register map (index):
  - 0 SEED[7:0], R/W
  - 1 CTRL: bit0 RUN, bits[2:1] MODE (00 static, 01 blink, 10 rotate-left, 11 bounce), bits[15:8] DUTY (see optional feature), R/W
  - 2 PERIOD[C_PERIOD_WIDTH-1:0], R/W
  - 3 STATUS: [15:0] step count, [17:16] FSM state, read-only; writes ignored
- Unused register bits read 0.
- Reset (synchronous, S_AXI_ARESETN==1): SEED=0, CTRL=0, PERIOD=0, step count=0, prescaler=0, dir=left, FSM=IDLE, LED=8'h00, step_tick=0.
- Write with slv_reg_wren=1 in cycle N updates the register at edge N+1.
- FSM states:
  - IDLE: LED<=SEED every cycle. RUN=1 -> LOAD.
  - LOAD: one cycle. pattern<=SEED, prescaler<=0, dir<=left, step count<=0. Goes to RUN_ST if RUN=1, else IDLE.
  - RUN_ST: prescaler increments. When prescaler == max(PERIOD,1)-1: prescaler<=0, pattern steps, step_tick=1, step count+=1 (wraps at 16'hFFFF->0). RUN=0 -> IDLE next cycle.
- Latency: CTRL write setting RUN at cycle N -> LOAD at N+1 -> RUN_ST at N+2 with LED=SEED. First step after max(PERIOD,1) cycles in RUN_ST.
- Step rules:
  - static: pattern unchanged; tick still pulses.
  - blink: pattern alternates SEED / 8'h00.
  - rotate: {p[6:0],p[7]}.
  - bounce: shift left (zero fill) while dir=left; when result has bit7 set, dir<=right; shift right until bit0 set, then dir<=left. SEED with multiple bits bounces on the MSB/LSB edge bits.
- LED = pattern in RUN_ST; LED = SEED in IDLE/LOAD.
- Boundaries:
  - PERIOD=0 is treated as 1, giving a step every cycle.
  - SEED=0 in rotate/bounce yields LED=0 forever; steps still counted.
  - CTRL write changing MODE while running re-enters LOAD, restarting the pattern.
  - SEED write while running takes effect only at the next LOAD.
  - PERIOD write clears the prescaler.
  - Reset mid-run returns everything to reset values in the same edge.
  - A write to CTRL coinciding with the step terminal: the write wins (LOAD); no step_tick.

Optional Feature:
LED_SEQ_PWM_EN
- Defined: a free-running 8-bit pwm counter drives LED = pattern & {8{pwm_cnt < DUTY}}, with DUTY=8'hFF forcing fully on. LED is registered after the gating. DUTY resets to 8'hFF.
- Undefined: no PWM logic. CTRL[15:8] is ignored and reads 0. LED = pattern.

Decomposition:
- Shared package (led_seq_pkg):
  - register index constants REG_SEED/REG_CTRL/REG_PERIOD/REG_STATUS
  - MODE encodings
  - FSM state encoding
  - CTRL bit positions
- One natural sub-module: led_step_unit. Combinational next-pattern from (pattern, mode, dir, seed), returning next pattern and next dir.

Test Plan:
- Reset: hold S_AXI_ARESETN=1 for 3 cycles -> LED=0x00, rd_data of every register =0, step_tick never pulses.
- Static: write SEED=0xA5, CTRL=0x1 -> LED=0xA5 from the cycle after the write; step_tick every cycle (PERIOD=0); STATUS step count increments by 1/cycle.
- Rotate: SEED=0x81, PERIOD=4, CTRL=0x5 -> LED 0x81, then 0x03 after 4 cycles, then 0x06; step_tick period 4.
- Bounce: SEED=0x01, PERIOD=1, CTRL=0x7 -> LED 0x01,0x02,...,0x80,0x40,...,0x01,0x02; check reversal at 0x80 and 0x01.
- Restart/stop: during blink (SEED=0x3C), write CTRL=0x5 mid-period -> LOAD, LED=0x3C, prescaler restarted. Then write CTRL=0 -> LED=SEED next cycle, FSM=IDLE in STATUS.
- PWM (with LED_SEQ_PWM_EN): SEED=0xFF, CTRL=0x4001 (DUTY=0x40) -> LED=0xFF for 64 of every 256 cycles, 0x00 otherwise. Without the macro: LED constantly 0xFF, CTRL reads 0x0001.
